// File: rtl/fpu_tag_sequencer.sv
// Tag-allocating issue/writeback sequencer that sits in front of the vector FPU.
// Commands get the lowest free tag and pass straight through to the FPU
// request port. Responses may return out of order; each tag's metadata is
// looked up and presented through a one-entry registered writeback stage.
module fpu_tag_sequencer #(
    parameter int WIDTH      = 512,
    parameter int TAG_WIDTH  = 2,
    parameter int META_WIDTH = 8
) (
    input  logic                  clock,
    input  logic                  reset,

    input  logic                  cmd_valid,
    output logic                  cmd_ready,
    input  logic [WIDTH-1:0]      cmd_operands_0,
    input  logic [WIDTH-1:0]      cmd_operands_1,
    input  logic [WIDTH-1:0]      cmd_operands_2,
    input  logic [2:0]            cmd_roundingMode,
    input  logic [4:0]            cmd_op,
    input  logic [2:0]            cmd_srcFormat,
    input  logic [2:0]            cmd_dstFormat,
    input  logic [1:0]            cmd_intFormat,
    input  logic [15:0]           cmd_simdMask,
    input  logic [META_WIDTH-1:0] cmd_meta,

    output logic                  req_valid,
    input  logic                  req_ready,
    output logic [WIDTH-1:0]      req_bits_operands_0,
    output logic [WIDTH-1:0]      req_bits_operands_1,
    output logic [WIDTH-1:0]      req_bits_operands_2,
    output logic [2:0]            req_bits_roundingMode,
    output logic [4:0]            req_bits_op,
    output logic [2:0]            req_bits_srcFormat,
    output logic [2:0]            req_bits_dstFormat,
    output logic [1:0]            req_bits_intFormat,
    output logic [15:0]           req_bits_simdMask,
    output logic [TAG_WIDTH-1:0]  req_bits_tag,
    output logic                  flush,

    input  logic                  resp_valid,
    output logic                  resp_ready,
    input  logic [WIDTH-1:0]      resp_bits_result,
    input  logic [4:0]            resp_bits_status,
    input  logic [TAG_WIDTH-1:0]  resp_bits_tag,

    output logic                  wb_valid,
    input  logic                  wb_ready,
    output logic [WIDTH-1:0]      wb_result,
    output logic [4:0]            wb_status,
    output logic [META_WIDTH-1:0] wb_meta,

    input  logic                  flush_req,
    output logic [TAG_WIDTH:0]    inflight_count,
    output logic                  busy,
    output logic                  err_bad_tag
);

    localparam int NUM_TAGS = 1 << TAG_WIDTH;
    localparam logic [TAG_WIDTH:0] COUNT_ONE = 1;

    logic [NUM_TAGS-1:0]   free_mask;
    logic [NUM_TAGS-1:0]   free_mask_next;
    logic [META_WIDTH-1:0] meta_table [NUM_TAGS];
    logic [TAG_WIDTH-1:0]  alloc_tag;
    logic                  alloc_found;
    logic                  tag_avail;
    logic                  issue_open;
    logic                  issue_fire;
    logic                  resp_fire;
    logic                  resp_tag_live;
    logic                  resp_good;
    logic                  resp_bad;

    // Lowest-index free tag, taken from the mask as it stood at the start of the cycle.
    always_comb begin
        alloc_tag   = '0;
        alloc_found = 1'b0;
        for (int i = 0; i < NUM_TAGS; i++) begin
            if (free_mask[i] && !alloc_found) begin
                alloc_tag   = TAG_WIDTH'(i);
                alloc_found = 1'b1;
            end
        end
    end

    // Issue/response handshakes; both are shut off while a flush is requested or in progress.
    always_comb begin
        tag_avail     = |free_mask;
        issue_open    = tag_avail & ~flush_req & ~flush;
        req_valid     = cmd_valid & issue_open;
        cmd_ready     = req_ready & issue_open;
        resp_ready    = (~wb_valid | wb_ready) & ~flush_req & ~flush;
        issue_fire    = req_valid & req_ready;
        resp_fire     = resp_valid & resp_ready;
        resp_tag_live = ~free_mask[resp_bits_tag];
        resp_good     = resp_fire & resp_tag_live;
        resp_bad      = resp_fire & ~resp_tag_live;
        busy          = (inflight_count != '0) | wb_valid;
    end

    // Command fields travel to the FPU unchanged alongside the allocated tag.
    always_comb begin
        req_bits_operands_0   = cmd_operands_0;
        req_bits_operands_1   = cmd_operands_1;
        req_bits_operands_2   = cmd_operands_2;
        req_bits_roundingMode = cmd_roundingMode;
        req_bits_op           = cmd_op;
        req_bits_srcFormat    = cmd_srcFormat;
        req_bits_dstFormat    = cmd_dstFormat;
        req_bits_intFormat    = cmd_intFormat;
        req_bits_simdMask     = cmd_simdMask;
        req_bits_tag          = alloc_tag;
    end

    // Issue and a good response always touch different tags, so both mask updates can apply.
    always_comb begin
        free_mask_next = free_mask;
        if (issue_fire) begin
            free_mask_next[alloc_tag] = 1'b0;
        end
        if (resp_good) begin
            free_mask_next[resp_bits_tag] = 1'b1;
        end
    end

    // Tag bookkeeping, in-flight count and the one-cycle flush pulse.
    always_ff @(posedge clock) begin
        if (reset) begin
            free_mask      <= '1;
            inflight_count <= '0;
            flush          <= 1'b0;
            err_bad_tag    <= 1'b0;
            for (int i = 0; i < NUM_TAGS; i++) begin
                meta_table[i] <= '0;
            end
        end else if (flush_req) begin
            free_mask      <= '1;
            inflight_count <= '0;
            flush          <= 1'b1;
        end else begin
            flush     <= 1'b0;
            free_mask <= free_mask_next;
            if (issue_fire) begin
                meta_table[alloc_tag] <= cmd_meta;
            end
            if (issue_fire && !resp_good) begin
                inflight_count <= inflight_count + COUNT_ONE;
            end else if (resp_good && !issue_fire) begin
                inflight_count <= inflight_count - COUNT_ONE;
            end
            if (resp_bad) begin
                err_bad_tag <= 1'b1;
            end
        end
    end

    // One-entry writeback register; a new response can reload it in the same cycle it drains.
    always_ff @(posedge clock) begin
        if (reset) begin
            wb_valid  <= 1'b0;
            wb_result <= '0;
            wb_status <= '0;
            wb_meta   <= '0;
        end else if (flush_req) begin
            wb_valid <= 1'b0;
        end else if (resp_good) begin
            wb_valid  <= 1'b1;
            wb_result <= resp_bits_result;
            wb_status <= resp_bits_status;
            wb_meta   <= meta_table[resp_bits_tag];
        end else if (wb_ready) begin
            wb_valid <= 1'b0;
        end
    end

endmodule

// File: tb/tb_fpu_tag_sequencer.sv
// Randomized scoreboard bench for fpu_tag_sequencer with a tag-set reference model.
module tb_fpu_tag_sequencer;

    localparam int WIDTH      = 512;
    localparam int TAG_WIDTH  = 2;
    localparam int META_WIDTH = 8;
    localparam int NUM_TAGS   = 1 << TAG_WIDTH;

    typedef struct packed {
        logic                 rst;
        logic                 cv;
        logic                 rr;
        logic                 rv;
        logic [TAG_WIDTH-1:0] rtag;
        logic                 wr;
        logic                 fr;
        logic [7:0]           meta;
        logic [31:0]          lane0;
    } stim_t;

    typedef struct packed {
        logic [WIDTH-1:0] result;
        logic [4:0]       status;
        logic [7:0]       meta;
    } wb_exp_t;

    logic                  clock = 1'b0;
    logic                  reset;
    logic                  cmd_valid;
    logic                  cmd_ready;
    logic [WIDTH-1:0]      cmd_operands_0, cmd_operands_1, cmd_operands_2;
    logic [2:0]            cmd_roundingMode;
    logic [4:0]            cmd_op;
    logic [2:0]            cmd_srcFormat, cmd_dstFormat;
    logic [1:0]            cmd_intFormat;
    logic [15:0]           cmd_simdMask;
    logic [META_WIDTH-1:0] cmd_meta;
    logic                  req_valid, req_ready;
    logic [WIDTH-1:0]      req_bits_operands_0, req_bits_operands_1, req_bits_operands_2;
    logic [2:0]            req_bits_roundingMode;
    logic [4:0]            req_bits_op;
    logic [2:0]            req_bits_srcFormat, req_bits_dstFormat;
    logic [1:0]            req_bits_intFormat;
    logic [15:0]           req_bits_simdMask;
    logic [TAG_WIDTH-1:0]  req_bits_tag;
    logic                  flush;
    logic                  resp_valid, resp_ready;
    logic [WIDTH-1:0]      resp_bits_result;
    logic [4:0]            resp_bits_status;
    logic [TAG_WIDTH-1:0]  resp_bits_tag;
    logic                  wb_valid, wb_ready;
    logic [WIDTH-1:0]      wb_result;
    logic [4:0]            wb_status;
    logic [META_WIDTH-1:0] wb_meta;
    logic                  flush_req;
    logic [TAG_WIDTH:0]    inflight_count;
    logic                  busy;
    logic                  err_bad_tag;

    int checks   = 0;
    int failures = 0;
    bit mon_en   = 0;

    // Reference model: which tags are outstanding and what metadata each carries.
    bit       allocated [NUM_TAGS];
    bit [7:0] tag_meta  [NUM_TAGS];
    int       model_count;
    bit       model_wbv;
    bit       model_flush;
    bit       model_err;
    wb_exp_t  sb_q [$];

    fpu_tag_sequencer #(.WIDTH(WIDTH), .TAG_WIDTH(TAG_WIDTH), .META_WIDTH(META_WIDTH)) dut (
        .clock(clock), .reset(reset),
        .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
        .cmd_operands_0(cmd_operands_0), .cmd_operands_1(cmd_operands_1), .cmd_operands_2(cmd_operands_2),
        .cmd_roundingMode(cmd_roundingMode), .cmd_op(cmd_op),
        .cmd_srcFormat(cmd_srcFormat), .cmd_dstFormat(cmd_dstFormat),
        .cmd_intFormat(cmd_intFormat), .cmd_simdMask(cmd_simdMask), .cmd_meta(cmd_meta),
        .req_valid(req_valid), .req_ready(req_ready),
        .req_bits_operands_0(req_bits_operands_0), .req_bits_operands_1(req_bits_operands_1),
        .req_bits_operands_2(req_bits_operands_2), .req_bits_roundingMode(req_bits_roundingMode),
        .req_bits_op(req_bits_op), .req_bits_srcFormat(req_bits_srcFormat),
        .req_bits_dstFormat(req_bits_dstFormat), .req_bits_intFormat(req_bits_intFormat),
        .req_bits_simdMask(req_bits_simdMask), .req_bits_tag(req_bits_tag), .flush(flush),
        .resp_valid(resp_valid), .resp_ready(resp_ready), .resp_bits_result(resp_bits_result),
        .resp_bits_status(resp_bits_status), .resp_bits_tag(resp_bits_tag),
        .wb_valid(wb_valid), .wb_ready(wb_ready), .wb_result(wb_result),
        .wb_status(wb_status), .wb_meta(wb_meta),
        .flush_req(flush_req), .inflight_count(inflight_count), .busy(busy), .err_bad_tag(err_bad_tag)
    );

    always #5 clock = ~clock;

    function automatic logic [WIDTH-1:0] rand_wide();
        logic [WIDTH-1:0] v;
        for (int i = 0; i < WIDTH / 32; i++) begin
            v[i*32 +: 32] = $urandom;
        end
        return v;
    endfunction

    function automatic stim_t mk(bit rst, bit cv, bit rr, bit rv, int rtag, bit wr, bit fr,
                                 logic [7:0] meta, logic [31:0] lane0);
        stim_t s;
        s.rst = rst; s.cv = cv; s.rr = rr; s.rv = rv; s.rtag = TAG_WIDTH'(rtag);
        s.wr = wr; s.fr = fr; s.meta = meta; s.lane0 = lane0;
        return s;
    endfunction

    task automatic checkOutput(input string name, input logic [WIDTH-1:0] actual,
                               input logic [WIDTH-1:0] expected);
        checks++;
        if (actual !== expected) begin
            failures++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, actual, expected, $time);
        end
    endtask

    task automatic model_clear();
        for (int i = 0; i < NUM_TAGS; i++) begin
            allocated[i] = 0;
            tag_meta[i]  = 0;
        end
        model_count = 0;
        model_wbv   = 0;
        model_flush = 0;
        model_err   = 0;
        sb_q.delete();
    endtask

    // Drive one cycle, check the DUT against the model, then advance the model.
    task automatic applyStimulus(input stim_t s);
        logic [WIDTH-1:0] res;
        logic [4:0]       st;
        int               free_cnt;
        int               exp_tag;
        bit               open, exp_req_valid, exp_cmd_ready, exp_resp_ready;
        @(posedge clock);
        #1;
        res = rand_wide();
        res[31:0] = s.lane0;
        st  = 5'($urandom);
        reset            = s.rst;
        cmd_valid        = s.cv;
        cmd_meta         = s.meta;
        cmd_operands_0   = rand_wide();
        cmd_operands_1   = rand_wide();
        cmd_operands_2   = rand_wide();
        cmd_roundingMode = 3'($urandom);
        cmd_op           = 5'($urandom);
        cmd_srcFormat    = 3'($urandom);
        cmd_dstFormat    = 3'($urandom);
        cmd_intFormat    = 2'($urandom);
        cmd_simdMask     = 16'($urandom);
        req_ready        = s.rr;
        resp_valid       = s.rv;
        resp_bits_tag    = s.rtag;
        resp_bits_result = res;
        resp_bits_status = st;
        wb_ready         = s.wr;
        flush_req        = s.fr;
        #1;
        free_cnt = 0;
        exp_tag  = -1;
        for (int i = 0; i < NUM_TAGS; i++) begin
            if (!allocated[i]) begin
                free_cnt++;
                if (exp_tag < 0) exp_tag = i;
            end
        end
        open           = (free_cnt > 0) && !s.fr && !model_flush;
        exp_req_valid  = s.cv && open;
        exp_cmd_ready  = s.rr && open;
        exp_resp_ready = (!model_wbv || s.wr) && !s.fr && !model_flush;
        checkOutput("req_valid", req_valid, exp_req_valid);
        checkOutput("cmd_ready", cmd_ready, exp_cmd_ready);
        checkOutput("resp_ready", resp_ready, exp_resp_ready);
        checkOutput("inflight_count", inflight_count, model_count);
        checkOutput("busy", busy, (model_count != 0) || model_wbv);
        checkOutput("wb_valid", wb_valid, model_wbv);
        checkOutput("flush", flush, model_flush);
        checkOutput("err_bad_tag", err_bad_tag, model_err);
        if (exp_req_valid) begin
            checkOutput("req_bits_tag", req_bits_tag, exp_tag);
            checkOutput("req_bits_op", req_bits_op, cmd_op);
            checkOutput("req_bits_operands_2", req_bits_operands_2, cmd_operands_2);
            checkOutput("req_bits_simdMask", req_bits_simdMask, cmd_simdMask);
        end
        @(negedge clock);
        #1;
        if (s.rst) begin
            model_clear();
        end else if (s.fr) begin
            for (int i = 0; i < NUM_TAGS; i++) allocated[i] = 0;
            model_count = 0;
            model_wbv   = 0;
            model_flush = 1;
            sb_q.delete();
        end else begin
            model_flush = 0;
            if (s.rv && exp_resp_ready && allocated[s.rtag]) begin
                sb_q.push_back('{result: res, status: st, meta: tag_meta[s.rtag]});
                allocated[s.rtag] = 0;
                model_count--;
                model_wbv = 1;
            end else begin
                if (s.rv && exp_resp_ready) model_err = 1;
                if (s.wr) model_wbv = 0;
            end
            if (exp_req_valid && s.rr) begin
                allocated[exp_tag] = 1;
                tag_meta[exp_tag]  = s.meta;
                model_count++;
            end
        end
    endtask

    // Scoreboard monitor: every accepted writeback must match the oldest expected entry.
    always @(negedge clock) begin
        wb_exp_t e;
        if (mon_en && wb_valid === 1'b1 && wb_ready === 1'b1) begin
            if (sb_q.size() == 0) begin
                checks++;
                failures++;
                $display("[TB] FAIL wb_unexpected: got writeback meta 0x%0h, expected none at %0t",
                         wb_meta, $time);
            end else begin
                e = sb_q.pop_front();
                checkOutput("wb_result", wb_result, e.result);
                checkOutput("wb_status", wb_status, e.status);
                checkOutput("wb_meta", wb_meta, e.meta);
            end
        end
    end

    function automatic stim_t idle();
        return mk(0, 0, 0, 0, 0, 1, 0, 8'h00, 32'h0);
    endfunction

    function automatic stim_t issue(logic [7:0] meta);
        return mk(0, 1, 1, 0, 0, 1, 0, meta, 32'h0);
    endfunction

    function automatic stim_t respond(int tag, bit wr);
        return mk(0, 0, 0, 1, tag, wr, 0, 8'h00, $urandom);
    endfunction

    function automatic stim_t do_reset();
        return mk(1, 0, 0, 0, 0, 0, 0, 8'h00, 32'h0);
    endfunction

    initial begin
        stim_t s;
        int    pick;
        reset = 1'b1; cmd_valid = 0; req_ready = 0; resp_valid = 0; wb_ready = 0; flush_req = 0;
        cmd_meta = 0; cmd_operands_0 = 0; cmd_operands_1 = 0; cmd_operands_2 = 0;
        cmd_roundingMode = 0; cmd_op = 0; cmd_srcFormat = 0; cmd_dstFormat = 0;
        cmd_intFormat = 0; cmd_simdMask = 0; resp_bits_tag = 0; resp_bits_result = 0;
        resp_bits_status = 0;
        repeat (3) @(posedge clock);
        model_clear();
        mon_en = 1;

        $display("[TB] single op");
        applyStimulus(issue(8'h2A));
        applyStimulus(idle());
        applyStimulus(idle());
        applyStimulus(mk(0, 0, 0, 1, 0, 1, 0, 8'h00, 32'h3F80_0000));
        applyStimulus(idle());
        applyStimulus(idle());

        $display("[TB] fill and refill");
        applyStimulus(do_reset());
        for (int i = 0; i < 5; i++) applyStimulus(issue(8'(8'h10 + i)));
        applyStimulus(respond(2, 1));
        applyStimulus(issue(8'h55));
        applyStimulus(issue(8'h56));

        $display("[TB] out of order");
        applyStimulus(do_reset());
        applyStimulus(issue(8'hA0));
        applyStimulus(issue(8'hB0));
        applyStimulus(issue(8'hC0));
        applyStimulus(respond(2, 1));
        applyStimulus(respond(0, 1));
        applyStimulus(respond(1, 1));
        applyStimulus(idle());

        $display("[TB] backpressure");
        applyStimulus(do_reset());
        applyStimulus(issue(8'h31));
        applyStimulus(issue(8'h32));
        applyStimulus(respond(0, 0));
        applyStimulus(respond(1, 0));
        applyStimulus(respond(1, 1));
        applyStimulus(idle());

        $display("[TB] same-cycle free and allocate");
        applyStimulus(do_reset());
        for (int i = 0; i < 3; i++) applyStimulus(issue(8'(8'h40 + i)));
        applyStimulus(mk(0, 1, 1, 1, 1, 1, 0, 8'h43, $urandom));
        applyStimulus(issue(8'h44));

        $display("[TB] flush and bad tag");
        applyStimulus(do_reset());
        for (int i = 0; i < 3; i++) applyStimulus(issue(8'(8'h60 + i)));
        applyStimulus(mk(0, 1, 1, 0, 0, 1, 1, 8'h00, 32'h0));
        applyStimulus(idle());
        applyStimulus(respond(1, 1));
        applyStimulus(idle());
        applyStimulus(do_reset());
        applyStimulus(idle());

        $display("[TB] random traffic");
        for (int n = 0; n < 3000; n++) begin
            s.rst  = ($urandom_range(0, 499) == 0);
            s.cv   = ($urandom_range(0, 3) != 0);
            s.rr   = ($urandom_range(0, 3) != 0);
            s.rv   = $urandom_range(0, 1);
            s.wr   = ($urandom_range(0, 2) != 0);
            s.fr   = ($urandom_range(0, 99) == 0);
            s.meta = 8'($urandom);
            s.lane0 = $urandom;
            s.rtag = TAG_WIDTH'($urandom);
            if ($urandom_range(0, 9) != 0) begin
                pick = $urandom_range(0, NUM_TAGS - 1);
                for (int k = 0; k < NUM_TAGS; k++) begin
                    if (allocated[(pick + k) % NUM_TAGS]) begin
                        s.rtag = TAG_WIDTH'((pick + k) % NUM_TAGS);
                        break;
                    end
                end
            end
            applyStimulus(s);
        end
        applyStimulus(idle());
        applyStimulus(idle());

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/fpu_tag_sequencer.md
Name: fpu_tag_sequencer

Overview:
- Initiator-side companion to the vector FPU wrapper: accepts FP commands from the core, allocates a tag per command, and drives the FPU req_* interface.
- Receives out-of-order FPU responses on resp_*, looks up the per-tag metadata (destination register, warp id, and so on), and presents a registered writeback to the register-file arbiter.
- Bounds in-flight operations to 2^TAG_WIDTH and owns FPU flush sequencing.

Parameters:
- WIDTH, 512, operand/result width in bits.
- TAG_WIDTH, 2, FPU tag width; NUM_TAGS = 2^TAG_WIDTH in-flight slots.
- META_WIDTH, 8, opaque writeback metadata carried per command.

Ports:
- clock  in  1  single clock.
- reset  in  1  synchronous, active-high.
- cmd_valid  in  1  command valid.
- cmd_ready  out  1  command accepted when high with cmd_valid.
- cmd_operands_0/1/2  in  WIDTH each  source operands.
- cmd_roundingMode  in  3  rounding mode.
- cmd_op  in  5  {op[3:0], op_mod}.
- cmd_srcFormat  in  3  source FP format.
- cmd_dstFormat  in  3  destination FP format.
- cmd_intFormat  in  2  integer format.
- cmd_simdMask  in  16  lane mask.
- cmd_meta  in  META_WIDTH  writeback metadata.
- req_valid  out  1  FPU request valid.
- req_ready  in  1  FPU ready.
- req_bits_operands_0/1/2  out  WIDTH each  passthrough of cmd operands.
- req_bits_roundingMode, req_bits_op, req_bits_srcFormat, req_bits_dstFormat, req_bits_intFormat, req_bits_simdMask  out  3/5/3/3/2/16  passthrough of the matching cmd fields.
- req_bits_tag  out  TAG_WIDTH  allocated tag.
- flush  out  1  FPU flush pulse.
- resp_valid  in  1  FPU response valid.
- resp_ready  out  1  response accepted.
- resp_bits_result  in  WIDTH  result.
- resp_bits_status  in  5  fflags.
- resp_bits_tag  in  TAG_WIDTH  returned tag.
- wb_valid  out  1  writeback valid.
- wb_ready  in  1  writeback accepted.
- wb_result  out  WIDTH  writeback data.
- wb_status  out  5  writeback fflags.
- wb_meta  out  META_WIDTH  writeback metadata.
- flush_req  in  1  core requests a pipeline kill.
- inflight_count  out  TAG_WIDTH+1  number of allocated tags.
- busy  out  1  high when inflight_count != 0 or wb_valid.
- err_bad_tag  out  1  sticky: response arrived for an unallocated tag.

Behaviour:
- Reset (synchronous, active-high, takes precedence over every other event):
  - free mask all ones; meta table cleared; wb_valid=0; wb_result/status/meta=0.
  - inflight_count=0, flush=0, err_bad_tag=0.
- Allocation:
  - alloc_tag is the lowest-index set bit of the free mask as registered at the start of the cycle.
  - tag_avail = |free_mask.
- Issue (combinational passthrough, zero latency):
  - req_valid = cmd_valid & tag_avail & ~flush_req & ~flush.
  - cmd_ready = req_ready & tag_avail & ~flush_req & ~flush.
  - req_bits_tag = alloc_tag.
- On issue fire (req_valid & req_ready):
  - clear free_mask[alloc_tag];
  - meta_table[alloc_tag] <= cmd_meta;
  - inflight_count++.
- Response acceptance:
  - resp_ready = ~wb_valid | wb_ready (one-entry registered output stage).
  - On resp fire with free_mask[tag]==0: latch wb_result/status/meta from meta_table[tag]; set wb_valid; set free_mask[tag]; inflight_count--. The freed tag is allocatable from the next cycle.
  - On resp fire with free_mask[tag]==1: drop the response, set err_bad_tag (sticky until reset); wb and count are unchanged.
- Writeback:
  - wb_valid clears on wb_valid & wb_ready unless a new response fires the same cycle. In that case the register reloads and wb_valid stays 1.
  - Back-to-back throughput is 1 per cycle.
- Simultaneous issue and response in the same cycle:
  - Both free-mask updates apply; the count is unchanged.
  - Issue cannot pick the tag being freed that cycle, since alloc_tag uses pre-cycle state.
- Full: free_mask == 0 → cmd_ready=0 and req_valid=0 until a response fires.
- Flush (flush_req sampled high in cycle N):
  - Cycle N: no issue; resp_ready forced 0.
  - Cycle N+1: flush=1 for exactly one cycle; free mask set to all ones; inflight_count=0; wb_valid=0; meta_table contents ignored.
  - Cycle N+2 onward: issue resumes; err_bad_tag is not set by flush.
  - flush_req held high keeps flush high on every cycle after the first and blocks issue.
- inflight_count never exceeds NUM_TAGS and never underflows; bad-tag responses do not decrement it.

Test Plan:
- Single op: cmd_meta=8'h2A, FPU returns tag 0 after 3 cycles with result 0x3F80_0000 in lane 0 → req_bits_tag=0; the cycle after the response, wb_valid=1, wb_meta=8'h2A, wb_result lane 0 = 0x3F80_0000; inflight_count goes 1→0.
- Fill (TAG_WIDTH=2): issue 4 cmds with req_ready=1 and no responses → tags 0,1,2,3; cmd_ready=0 on the 5th; inflight_count=4; a response on tag 2 lets the next issue get tag 2 one cycle later.
- Out-of-order: issue meta A,B,C on tags 0,1,2; responses arrive with tags 2,0,1 → wb_meta sequence C,A,B, each with matching status.
- Backpressure: hold wb_ready=0 while two responses arrive → the first latches and resp_ready=0 for the second; raising wb_ready accepts the second the same cycle with wb_valid held at 1.
- Same-cycle free/alloc: one tag free (3) and tag 1 responding while a cmd is valid → the cmd issues on tag 3; next cycle's alloc_tag=1; inflight_count unchanged.
- Flush/bad tag: 3 in flight, pulse flush_req → flush high exactly one cycle later, inflight_count=0, busy=0. A later resp with tag 1 sets err_bad_tag=1 with wb_valid staying 0; reset clears it.
